ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch stage, directly upstream of decode. Owns the PC and issues
//  one read at a time to instruction memory over a valid/ready AR/R channel pair.
//  Holds each returned instruction in a one-entry buffer until decode accepts it.
//  Takes redirects (branch, jump, trap) from execute and discards stale fetches.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC value loaded on reset
//  INST_NOP   32'h0000_0013  instruction word emitted with a fault (addi x0,x0,0)
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  rst             in   1   reset, asynchronous assert, active-high
//  redirect_valid  in   1   execute requests PC change this cycle
//  redirect_pc     in   32  new fetch address
//  araddr          out  32  instruction read address
//  arvalid         out  1   read request valid
//  arready         in   1   memory accepts request
//  rdata           in   32  returned instruction word
//  rresp           in   2   0 = OK, nonzero = bus error
//  rvalid          in   1   response valid
//  rready          out  1   fetch accepts response
//  inst_valid      out  1   buffered instruction valid toward decode
//  inst_ready      in   1   decode accepts instruction
//  inst            out  32  instruction word
//  inst_pc         out  32  address of inst
//  inst_fault      out  1   1 = bus error or misaligned fetch; inst = INST_NOP
// BEHAVIOUR
//  Reset values: pc=RESET_PC, state=REQ, arvalid=0, araddr=0, rready=0,
//   inst_valid=0, inst=0, inst_pc=0, inst_fault=0, kill=0.
//  States: REQ, WAIT. The first request is issued in the first cycle after rst
//   deasserts.
//  REQ:
//   - Drives arvalid=1 and araddr=pc. araddr stays stable until arready.
//   - arvalid is never withdrawn before the handshake completes.
//   - On arvalid&arready: go to WAIT and latch req_pc=pc.
//  WAIT:
//   - rready = !inst_valid | inst_ready. A response is taken only when the buffer
//     is free or being drained in the same cycle.
//   - rvalid is ignored in any other state.
//  On rvalid&rready with kill=0:
//   - Load inst=rdata, inst_pc=req_pc, inst_fault=(rresp!=0).
//   - If rresp!=0, load inst=INST_NOP instead of rdata.
//   - Set inst_valid=1, pc=req_pc+4, then go to REQ.
//  On rvalid&rready with kill=1:
//   - Drop the data, clear kill, go to REQ. pc already holds the redirect target.
//  Latency: inst_valid rises at minimum 2 cycles after the arvalid&arready cycle.
//   Steady-state throughput is 1 instruction per 2 cycles.
//  Output buffer:
//   - inst_valid stays high, with inst, inst_pc and inst_fault stable, until
//     inst_valid&inst_ready.
//   - inst_valid clears on that handshake unless a new response loads in the
//     same cycle.
//  Redirect (highest priority, any state):
//   - pc <= redirect_pc.
//   - inst_valid <= 0. A handshake in the redirect cycle still counts; decode
//     flushes itself.
//   - If an AR is outstanding or arvalid=1, set kill=1. Its response is dropped.
//     A redirect coincident with rvalid&rready drops that response too.
//   - If state=REQ and arvalid=1 without arready, the stale request must still
//     complete (araddr unchanged). kill=1 then drops its response.
//  Misaligned target (redirect_pc[1:0]!=0):
//   - No bus request is made.
//   - Once any kill has cleared and the buffer is free: inst_valid=1,
//     inst_fault=1, inst=INST_NOP, inst_pc=redirect_pc.
//   - Fetch then stalls in REQ with arvalid=0 until the next redirect.
//  PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0, with no flag.
//  rst asserted mid-transaction returns all state to reset values immediately.
//   The memory side is reset by the same rst.
// TESTING
//  1. Reset release, arready=1, rvalid 1 cycle later with rdata=32'h0010_0093,
//     inst_ready=1 -> araddr=0x8000_0000; inst_valid with inst=0x0010_0093,
//     inst_pc=0x8000_0000; next araddr=0x8000_0004.
//  2. inst_ready=0 for 5 cycles while next rvalid=1 held -> rready=0; inst/inst_pc
//     stable; the second word loads the cycle inst_ready rises.
//  3. Redirect to 0x8000_0100 while in WAIT, then rvalid with stale data ->
//     stale word never appears; next araddr=0x8000_0100.
//  4. rresp=2'b10 on fetch at 0x8000_0008 -> inst_fault=1, inst=0x0000_0013,
//     inst_pc=0x8000_0008; next fetch at 0x8000_000C.
//  5. Redirect to 0x8000_0102 -> no arvalid; inst_fault=1, inst_pc=0x8000_0102;
//     fetch stalls until redirect to 0x8000_0200.
//  6. rst pulsed while arvalid=1 and arready=0 -> all outputs at reset values in
//     the same cycle; refetch from RESET_PC after release.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, keeps one read in flight, buffers one instruction for decode.
// Latency: inst_valid rises 2 cycles after the AR handshake at best. Throughput: 1 instruction per 2 cycles.
// Backpressure: the response is refused while the buffer is full and not draining. AR is held until arready.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  typedef enum logic {REQ = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic        flt_pend_q, flt_pend_d;
  logic        arvalid_d;
  logic [31:0] araddr_d;
  logic        inst_valid_d;
  logic [31:0] inst_d;
  logic [31:0] inst_pc_d;
  logic        inst_fault_d;
  logic        buf_free;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    kill_d       = kill_q;
    flt_pend_d   = flt_pend_q;
    arvalid_d    = arvalid;
    araddr_d     = araddr;
    inst_valid_d = inst_valid;
    inst_d       = inst;
    inst_pc_d    = inst_pc;
    inst_fault_d = inst_fault;
    rready       = 1'b0;
    buf_free     = !inst_valid || inst_ready;

    if (inst_valid && inst_ready) inst_valid_d = 1'b0;

    case (state_q)
      REQ: begin
        if (arvalid && arready) begin
          arvalid_d = 1'b0;
          state_d   = WAIT;
          req_pc_d  = araddr;
        end else if (!arvalid) begin
          // A misaligned target reports its fault once, then fetch parks here.
          if (flt_pend_q && !kill_q && buf_free) begin
            inst_valid_d = 1'b1;
            inst_d       = INST_NOP;
            inst_pc_d    = pc_q;
            inst_fault_d = 1'b1;
            flt_pend_d   = 1'b0;
          end else if (pc_q[1:0] == 2'b00) begin
            arvalid_d = 1'b1;
            araddr_d  = pc_q;
          end
        end
      end
      WAIT: begin
        rready = buf_free;
        if (rvalid && buf_free) begin
          state_d = REQ;
          if (kill_q || redirect_valid) begin
            kill_d = 1'b0;
            if (pc_q[1:0] == 2'b00) begin
              arvalid_d = 1'b1;
              araddr_d  = pc_q;
            end
          end else begin
            inst_valid_d = 1'b1;
            inst_d       = (rresp != 2'b00) ? INST_NOP : rdata;
            inst_pc_d    = req_pc_q;
            inst_fault_d = (rresp != 2'b00);
            pc_d         = req_pc_q + 32'd4;
            // Issue the next request straight away to sustain 1 per 2 cycles.
            arvalid_d    = 1'b1;
            araddr_d     = req_pc_q + 32'd4;
          end
        end
      end
      default: state_d = REQ;
    endcase

    if (redirect_valid) begin
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      flt_pend_d   = |redirect_pc[1:0];
      if ((state_q == WAIT && !(rvalid && buf_free)) || (state_q == REQ && arvalid))
        kill_d = 1'b1;
      // A request already on the bus must complete unchanged; anything new waits a cycle.
      if (!arvalid) arvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'd0;
      kill_q     <= 1'b0;
      flt_pend_q <= 1'b0;
      arvalid    <= 1'b0;
      araddr     <= 32'd0;
      inst_valid <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= 32'd0;
      inst_fault <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      kill_q     <= kill_d;
      flt_pend_q <= flt_pend_d;
      arvalid    <= arvalid_d;
      araddr     <= araddr_d;
      inst_valid <= inst_valid_d;
      inst       <= inst_d;
      inst_pc    <= inst_pc_d;
      inst_fault <= inst_fault_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios, then a randomized run scored against an instruction-stream model.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int errors = 0;
  int checks = 0;
  logic [31:0] salt;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ salt;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[4:2] == salt[2:0];
  endfunction

  // Waits (bounded) for an AR request, accepts it for one cycle, returns its address.
  task automatic ar_accept(output logic [31:0] a, output logic ok);
    ok = 1'b0;
    a  = 32'hx;
    for (int i = 0; i < 20; i++) begin
      if (arvalid) begin
        a = araddr;
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    if (ok) begin
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
    end
  endtask

  // Presents one response until it is accepted (bounded); returns at the negedge after the handshake.
  task automatic r_give(input logic [31:0] d, input logic [1:0] resp, output logic ok);
    ok = 1'b0;
    rvalid = 1'b1; rdata = d; rresp = resp;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    rvalid = 1'b0; rresp = 2'b00;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%b want=0", arvalid); end
    checks++; if (araddr !== 32'd0) begin errors++; $display("FAIL reset_araddr got=%h want=0", araddr); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready got=%b want=0", rready); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got=%b want=0", inst_valid); end
    checks++; if ({inst, inst_pc, inst_fault} !== 65'd0) begin errors++; $display("FAIL reset_inst got=%h/%h/%b want=0/0/0", inst, inst_pc, inst_fault); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] a; logic ok;
    inst_ready = 1'b1;
    ar_accept(a, ok);
    checks++; if (!ok || a !== RST_PC) begin errors++; $display("FAIL basic_araddr got=%h ok=%b want=%h", a, ok, RST_PC); end
    r_give(32'h0010_0093, 2'b00, ok); #1;
    checks++; if ({ok, inst_valid, inst, inst_pc, inst_fault} !== {1'b1, 1'b1, 32'h0010_0093, RST_PC, 1'b0})
      begin errors++; $display("FAIL basic_inst got ok=%b v=%b %h @%h f=%b want v=1 00100093 @80000000 f=0", ok, inst_valid, inst, inst_pc, inst_fault); end
    checks++; if ({arvalid, araddr} !== {1'b1, 32'h8000_0004}) begin errors++; $display("FAIL basic_next got %b/%h want 1/80000004", arvalid, araddr); end
  endtask

  task automatic test_bus_error;
    logic [31:0] a; logic ok;
    ar_accept(a, ok);
    r_give(32'h1111_1111, 2'b00, ok);
    ar_accept(a, ok);
    checks++; if (!ok || a !== 32'h8000_0008) begin errors++; $display("FAIL buserr_araddr got=%h want=80000008", a); end
    r_give(32'hDEAD_BEEF, 2'b10, ok); #1;
    checks++; if ({inst_valid, inst, inst_pc, inst_fault} !== {1'b1, NOP, 32'h8000_0008, 1'b1})
      begin errors++; $display("FAIL buserr_inst got v=%b %h @%h f=%b want 1 00000013 @80000008 1", inst_valid, inst, inst_pc, inst_fault); end
    checks++; if ({arvalid, araddr} !== {1'b1, 32'h8000_000C}) begin errors++; $display("FAIL buserr_next got %b/%h want 1/8000000c", arvalid, araddr); end
  endtask

  task automatic test_backpressure;
    logic [31:0] a; logic ok;
    inst_ready = 1'b0;
    ar_accept(a, ok);
    rvalid = 1'b1; rdata = 32'h0040_0213; rresp = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rready !== 1'b0) begin errors++; $display("FAIL bp_rready cycle=%0d got=%b want=0", i, rready); end
      checks++; if ({inst_valid, inst, inst_pc} !== {1'b1, NOP, 32'h8000_0008})
        begin errors++; $display("FAIL bp_hold cycle=%0d got %b %h @%h want 1 00000013 @80000008", i, inst_valid, inst, inst_pc); end
      @(negedge clk);
    end
    inst_ready = 1'b1; #1;
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL bp_release_rready got=%b want=1", rready); end
    @(negedge clk);
    rvalid = 1'b0; #1;
    checks++; if ({inst_valid, inst, inst_pc, inst_fault} !== {1'b1, 32'h0040_0213, 32'h8000_000C, 1'b0})
      begin errors++; $display("FAIL bp_load got %b %h @%h f=%b want 1 00400213 @8000000c 0", inst_valid, inst, inst_pc, inst_fault); end
  endtask

  task automatic test_redirect_wait;
    logic [31:0] a; logic ok;
    ar_accept(a, ok);
    checks++; if (!ok || a !== 32'h8000_0010) begin errors++; $display("FAIL rdw_araddr got=%h want=80000010", a); end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    checks++; if ({inst_valid, arvalid} !== 2'b00) begin errors++; $display("FAIL rdw_quiet got v=%b ar=%b want 0 0", inst_valid, arvalid); end
    r_give(32'hBAD0_BAD0, 2'b00, ok); #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdw_stale got v=%b inst=%h want v=0", inst_valid, inst); end
    checks++; if ({arvalid, araddr} !== {1'b1, 32'h8000_0100}) begin errors++; $display("FAIL rdw_next got %b/%h want 1/80000100", arvalid, araddr); end
    ar_accept(a, ok);
    r_give(32'h0050_0293, 2'b00, ok); #1;
    checks++; if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0050_0293, 32'h8000_0100})
      begin errors++; $display("FAIL rdw_target got %b %h @%h want 1 00500293 @80000100", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_wrap;
    logic [31:0] a; logic ok;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    ar_accept(a, ok);
    checks++; if (!ok || a !== 32'h8000_0104) begin errors++; $display("FAIL wrap_stale_ar got=%h want=80000104", a); end
    r_give(32'hBAD1_BAD1, 2'b00, ok);
    ar_accept(a, ok);
    checks++; if (!ok || a !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_araddr got=%h want=fffffffc", a); end
    r_give(32'h0070_0393, 2'b00, ok); #1;
    checks++; if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0070_0393, 32'hFFFF_FFFC})
      begin errors++; $display("FAIL wrap_inst got %b %h @%h want 1 00700393 @fffffffc", inst_valid, inst, inst_pc); end
    checks++; if ({arvalid, araddr} !== {1'b1, 32'h0000_0000}) begin errors++; $display("FAIL wrap_next got %b/%h want 1/00000000", arvalid, araddr); end
  endtask

  task automatic test_misaligned;
    logic [31:0] a; logic ok; logic stray;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    checks++; if ({arvalid, araddr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL mis_stale_hold got %b/%h want 1/00000000", arvalid, araddr); end
    ar_accept(a, ok);
    r_give(32'hBAD2_BAD2, 2'b00, ok);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (inst_valid) break;
      @(negedge clk);
    end
    checks++; if ({inst_valid, inst, inst_pc, inst_fault} !== {1'b1, NOP, 32'h8000_0102, 1'b1})
      begin errors++; $display("FAIL mis_fault got %b %h @%h f=%b want 1 00000013 @80000102 1", inst_valid, inst, inst_pc, inst_fault); end
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (arvalid || inst_valid) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL mis_stall got activity=%b want 0", stray); end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    ar_accept(a, ok);
    checks++; if (!ok || a !== 32'h8000_0200) begin errors++; $display("FAIL mis_resume got=%h want=80000200", a); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] a; logic ok;
    r_give(32'h0060_0313, 2'b00, ok); #1;
    checks++; if ({arvalid, araddr} !== {1'b1, 32'h8000_0204}) begin errors++; $display("FAIL rstmid_pre got %b/%h want 1/80000204", arvalid, araddr); end
    rst = 1'b1; #1;
    checks++; if ({arvalid, araddr, rready} !== 34'd0) begin errors++; $display("FAIL rstmid_bus got %b/%h/%b want 0", arvalid, araddr, rready); end
    checks++; if ({inst_valid, inst, inst_pc, inst_fault} !== 66'd0) begin errors++; $display("FAIL rstmid_inst got %b %h %h %b want 0", inst_valid, inst, inst_pc, inst_fault); end
    @(negedge clk);
    rst = 1'b0;
    ar_accept(a, ok);
    checks++; if (!ok || a !== RST_PC) begin errors++; $display("FAIL rstmid_refetch got=%h want=80000000", a); end
  endtask

  // Model: decode must see the sequential stream from the last redirect target;
  // a misaligned target yields exactly one NOP fault, then silence.
  task automatic test_random;
    logic [31:0] exp_pc, mem_addr, hold_addr, ei;
    logic        mem_busy, stalled, ar_hold, ef;
    int          mem_wait, idle, accepted;
    rst = 1'b1; rvalid = 1'b0; arready = 1'b0; redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_pc = RST_PC; mem_busy = 1'b0; mem_addr = 32'd0; mem_wait = 0;
    stalled = 1'b0; ar_hold = 1'b0; hold_addr = 32'd0; idle = 0; accepted = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      arready = !mem_busy && ($urandom_range(0, 2) != 0);
      if (mem_busy && mem_wait == 0) begin
        rvalid = 1'b1; rdata = mem_word(mem_addr); rresp = mem_err(mem_addr) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0; rdata = $urandom; rresp = 2'b00;
      end
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 7))
        0: redirect_pc = RST_PC + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
        1: redirect_pc = 32'hFFFF_FFF8;
        default: redirect_pc = RST_PC + 32'($urandom_range(0, 63)) * 4;
      endcase
      #1;
      if (ar_hold) begin
        checks++; if ({arvalid, araddr} !== {1'b1, hold_addr}) begin errors++; $display("FAIL rnd_ar_hold cyc=%0d got %b/%h want 1/%h", cyc, arvalid, araddr, hold_addr); end
      end
      if (arvalid && arready) begin
        checks++; if (araddr[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_ar_align cyc=%0d got=%h", cyc, araddr); end
      end
      if (stalled) begin
        checks++; if ({arvalid, inst_valid} !== 2'b00) begin errors++; $display("FAIL rnd_stall cyc=%0d got ar=%b v=%b want 0 0", cyc, arvalid, inst_valid); end
      end
      if (inst_valid && inst_ready) begin
        if (exp_pc[1:0] != 2'b00) begin ef = 1'b1; ei = NOP; end
        else begin ef = mem_err(exp_pc); ei = ef ? NOP : mem_word(exp_pc); end
        checks++; if ({inst_pc, inst, inst_fault} !== {exp_pc, ei, ef})
          begin errors++; $display("FAIL rnd_inst cyc=%0d got %h @%h f=%b want %h @%h f=%b", cyc, inst, inst_pc, inst_fault, ei, exp_pc, ef); end
        if (exp_pc[1:0] != 2'b00) stalled = 1'b1;
        else exp_pc = exp_pc + 32'd4;
        accepted++;
        idle = 0;
      end
      if (redirect_valid) begin exp_pc = redirect_pc; stalled = 1'b0; idle = 0; end
      if (stalled) idle = 0;
      idle++;
      if (idle > 400) begin
        errors++; checks++;
        $display("FAIL rnd_liveness cyc=%0d no instruction for %0d cycles", cyc, idle);
        break;
      end
      if (mem_busy && mem_wait > 0) mem_wait--;
      if (rvalid && rready) mem_busy = 1'b0;
      if (arvalid && arready) begin mem_busy = 1'b1; mem_addr = araddr; mem_wait = $urandom_range(0, 2); end
      ar_hold = arvalid && !arready;
      hold_addr = araddr;
    end
    redirect_valid = 1'b0; rvalid = 1'b0; arready = 1'b0;
    checks++; if (accepted < 200) begin errors++; $display("FAIL rnd_volume got=%0d want>=200", accepted); end
  endtask

  initial begin
    salt = $urandom;
    test_reset;
    test_basic;
    test_bus_error;
    test_backpressure;
    test_redirect_wait;
    test_wrap;
    test_misaligned;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
